// File: rtl/llc_set_table_pkg.sv
// Shared constants, entry type and width helpers for the LLC in-flight set table.
// LLC_SET_BITS sits with the other cache_consts values; the table depth default sits beside it.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 10
`endif

package llc_set_table_pkg;

    localparam int LLC_SET_BITS        = `LLC_SET_BITS;
    localparam int LLC_SET_TABLE_DEPTH = 8;

    typedef struct packed {
        logic                    valid;
        logic [LLC_SET_BITS-1:0] tag;
    } llc_set_entry_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/llc_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag; idx is 0 when nothing is set.
module llc_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/llc_set_table_alloc.sv
// In-flight LLC set table: parallel conflict lookups, lowest-free-slot allocation,
// release by slot index, with registered occupancy and a sticky bad-release flag.
module llc_set_table_alloc
    import llc_set_table_pkg::*;
#(
    parameter int SET_BITS   = `LLC_SET_BITS,
    parameter int DEPTH      = LLC_SET_TABLE_DEPTH,
    parameter int NUM_LOOKUP = 2,
    parameter bit ALLOW_DUP  = 1'b0,
    localparam int IDX_W     = idx_width(DEPTH),
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LOOKUP-1:0]          lookup_valid,
    input  logic [NUM_LOOKUP*SET_BITS-1:0] lookup_set,
    output logic [NUM_LOOKUP-1:0]          lookup_hit,
    output logic [NUM_LOOKUP*IDX_W-1:0]    lookup_idx,
    input  logic                           alloc_valid,
    input  logic [SET_BITS-1:0]            alloc_set,
    output logic                           alloc_ready,
    output logic [IDX_W-1:0]               alloc_idx,
    input  logic                           release_valid,
    input  logic [IDX_W-1:0]               release_idx,
    output logic [CNT_W-1:0]               occupancy,
    output logic                           full,
    output logic                           empty,
    output logic                           err_release
);

    logic [DEPTH-1:0]    entry_valid;
    logic [SET_BITS-1:0] entry_tag [DEPTH];

    logic [DEPTH-1:0] dup_match;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             alloc_fire;
    logic             rel_in_range;
    logic             rel_hit;
    logic             rel_fire;

    // Lookups and allocation decisions all see pre-edge state only.
    for (genvar p = 0; p < NUM_LOOKUP; p++) begin : g_lookup
        logic [DEPTH-1:0] match;
        logic             found;
        logic [IDX_W-1:0] idx;

        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                match[i] = entry_valid[i] && (entry_tag[i] == lookup_set[p*SET_BITS +: SET_BITS]);
            end
        end

        llc_prio_enc #(.WIDTH(DEPTH), .IDX_W(IDX_W)) u_match_enc (
            .req   (match),
            .found (found),
            .idx   (idx)
        );

        assign lookup_hit[p]                 = lookup_valid[p] && found;
        assign lookup_idx[p*IDX_W +: IDX_W]  = lookup_hit[p] ? idx : '0;
    end

    llc_prio_enc #(.WIDTH(DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .req   (~entry_valid),
        .found (free_found),
        .idx   (free_idx)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dup_match[i] = entry_valid[i] && (entry_tag[i] == alloc_set);
        end
    end

    assign full        = (occupancy == CNT_W'(DEPTH));
    assign empty       = (occupancy == '0);
    assign alloc_ready = !full && (ALLOW_DUP || !(|dup_match));
    assign alloc_idx   = free_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign rel_in_range = ({1'b0, release_idx} < (IDX_W + 1)'(DEPTH));

    always_comb begin
        rel_hit = 1'b0;
        if (rel_in_range) rel_hit = entry_valid[release_idx];
    end

    assign rel_fire = release_valid && rel_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) entry_tag[i] <= '0;
            occupancy   <= '0;
            err_release <= 1'b0;
        end else begin
            // Alloc only targets invalid slots and release only valid ones, so they never collide.
            if (alloc_fire) begin
                entry_valid[free_idx] <= 1'b1;
                entry_tag[free_idx]   <= alloc_set;
            end
            if (rel_fire) entry_valid[release_idx] <= 1'b0;

            case ({alloc_fire, rel_fire})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase

            if (release_valid && !rel_hit) err_release <= 1'b1;
        end
    end

    a_occ_bound : assert property (@(posedge clk) disable iff (rst)
        occupancy <= CNT_W'(DEPTH));
    a_occ_popcount : assert property (@(posedge clk) disable iff (rst)
        $countones(entry_valid) == int'(occupancy));
    a_free_consistent : assert property (@(posedge clk) disable iff (rst)
        free_found == !full);

endmodule

// File: tb/tb_llc_set_table_alloc.sv
// Directed bench for llc_set_table_alloc: vector table for the main sequence,
// hand sequences for asynchronous reset and duplicate-allowed allocation.
module tb_llc_set_table_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [1:0]  lookup_valid;
    logic [19:0] lookup_set;
    logic [1:0]  lookup_hit;
    logic [5:0]  lookup_idx;
    logic        alloc_valid;
    logic [9:0]  alloc_set;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        release_valid;
    logic [2:0]  release_idx;
    logic [3:0]  occupancy;
    logic        full;
    logic        empty;
    logic        err_release;

    logic [1:0]  d_lookup_valid;
    logic [9:0]  d_lookup_set;
    logic [1:0]  d_lookup_hit;
    logic [5:0]  d_lookup_idx;
    logic        d_alloc_valid;
    logic [9:0]  d_alloc_set;
    logic        d_alloc_ready;
    logic [2:0]  d_alloc_idx;
    logic [3:0]  d_occupancy;
    logic        d_full;
    logic        d_empty;
    logic        d_err_release;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    llc_set_table_alloc #(.SET_BITS(10), .DEPTH(8), .NUM_LOOKUP(2), .ALLOW_DUP(1'b0)) dut (
        .clk           (clk),
        .rst           (rst),
        .lookup_valid  (lookup_valid),
        .lookup_set    (lookup_set),
        .lookup_hit    (lookup_hit),
        .lookup_idx    (lookup_idx),
        .alloc_valid   (alloc_valid),
        .alloc_set     (alloc_set),
        .alloc_ready   (alloc_ready),
        .alloc_idx     (alloc_idx),
        .release_valid (release_valid),
        .release_idx   (release_idx),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .err_release   (err_release)
    );

    llc_set_table_alloc #(.SET_BITS(10), .DEPTH(8), .NUM_LOOKUP(2), .ALLOW_DUP(1'b1)) dut_dup (
        .clk           (clk),
        .rst           (rst),
        .lookup_valid  (d_lookup_valid),
        .lookup_set    ({10'h000, d_lookup_set}),
        .lookup_hit    (d_lookup_hit),
        .lookup_idx    (d_lookup_idx),
        .alloc_valid   (d_alloc_valid),
        .alloc_set     (d_alloc_set),
        .alloc_ready   (d_alloc_ready),
        .alloc_idx     (d_alloc_idx),
        .release_valid (1'b0),
        .release_idx   (3'd0),
        .occupancy     (d_occupancy),
        .full          (d_full),
        .empty         (d_empty),
        .err_release   (d_err_release)
    );

    typedef struct {
        logic       av;
        logic [9:0] aset;
        logic       rv;
        logic [2:0] ridx;
        logic [1:0] lv;
        logic [9:0] ls0;
        logic [9:0] ls1;
        logic       e_ardy;
        logic [2:0] e_aidx;
        logic [1:0] e_hit;
        logic [2:0] e_idx0;
        logic [2:0] e_idx1;
        logic [3:0] e_occ;
        logic       e_full;
        logic       e_empty;
        logic       e_err;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic av, input logic [9:0] aset, input logic rv,
                                input logic [2:0] ridx, input logic [1:0] lv,
                                input logic [9:0] ls0, input logic [9:0] ls1,
                                input logic e_ardy, input logic [2:0] e_aidx,
                                input logic [1:0] e_hit, input logic [2:0] e_idx0,
                                input logic [2:0] e_idx1, input logic [3:0] e_occ,
                                input logic e_full, input logic e_empty, input logic e_err);
        vec_t v;
        v.av = av; v.aset = aset; v.rv = rv; v.ridx = ridx; v.lv = lv; v.ls0 = ls0; v.ls1 = ls1;
        v.e_ardy = e_ardy; v.e_aidx = e_aidx; v.e_hit = e_hit; v.e_idx0 = e_idx0;
        v.e_idx1 = e_idx1; v.e_occ = e_occ; v.e_full = e_full; v.e_empty = e_empty;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid    = 1'b0;
        alloc_set      = 10'h3FF;
        release_valid  = 1'b0;
        release_idx    = 3'd0;
        lookup_valid   = 2'b00;
        lookup_set     = '0;
        d_alloc_valid  = 1'b0;
        d_alloc_set    = 10'h000;
        d_lookup_valid = 2'b00;
        d_lookup_set   = 10'h000;
    endtask

    initial begin
        logic [31:0] act;
        logic [31:0] exp;
        logic [2:0]  aidx_act;
        logic [2:0]  aidx_exp;

        idle_inputs();

        //            av aset    rv ridx lv     ls0     ls1     rdy aidx hit    i0 i1 occ full emp err
        vecs[0]  = mk(0, 10'h3FF, 0, 0, 2'b01, 10'h000, 10'h000, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 10'h000, 0, 0, 2'b00, 10'h000, 10'h000, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 10'h001, 0, 0, 2'b00, 10'h000, 10'h000, 1, 1, 2'b00, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mk(1, 10'h002, 0, 0, 2'b00, 10'h000, 10'h000, 1, 2, 2'b00, 0, 0, 2, 0, 0, 0);
        vecs[4]  = mk(1, 10'h003, 0, 0, 2'b00, 10'h000, 10'h000, 1, 3, 2'b00, 0, 0, 3, 0, 0, 0);
        vecs[5]  = mk(1, 10'h004, 0, 0, 2'b00, 10'h000, 10'h000, 1, 4, 2'b00, 0, 0, 4, 0, 0, 0);
        vecs[6]  = mk(1, 10'h005, 0, 0, 2'b00, 10'h000, 10'h000, 1, 5, 2'b00, 0, 0, 5, 0, 0, 0);
        vecs[7]  = mk(1, 10'h006, 0, 0, 2'b00, 10'h000, 10'h000, 1, 6, 2'b00, 0, 0, 6, 0, 0, 0);
        vecs[8]  = mk(1, 10'h007, 0, 0, 2'b00, 10'h000, 10'h000, 1, 7, 2'b00, 0, 0, 7, 0, 0, 0);
        vecs[9]  = mk(0, 10'h3FF, 0, 0, 2'b11, 10'h000, 10'h007, 0, 0, 2'b11, 0, 7, 8, 1, 0, 0);
        vecs[10] = mk(0, 10'h3FF, 1, 3, 2'b01, 10'h003, 10'h000, 0, 0, 2'b01, 3, 0, 8, 1, 0, 0);
        vecs[11] = mk(1, 10'h01F, 0, 0, 2'b01, 10'h003, 10'h000, 1, 3, 2'b00, 0, 0, 7, 0, 0, 0);
        vecs[12] = mk(0, 10'h3FF, 0, 0, 2'b11, 10'h01F, 10'h003, 0, 0, 2'b01, 3, 0, 8, 1, 0, 0);
        vecs[13] = mk(0, 10'h3FF, 1, 0, 2'b00, 10'h000, 10'h000, 0, 0, 2'b00, 0, 0, 8, 1, 0, 0);
        vecs[14] = mk(1, 10'h005, 0, 0, 2'b01, 10'h005, 10'h000, 0, 0, 2'b01, 5, 0, 7, 0, 0, 0);
        vecs[15] = mk(1, 10'h02A, 0, 0, 2'b01, 10'h005, 10'h000, 1, 0, 2'b01, 5, 0, 7, 0, 0, 0);
        vecs[16] = mk(1, 10'h033, 1, 2, 2'b01, 10'h002, 10'h000, 0, 0, 2'b01, 2, 0, 8, 1, 0, 0);
        vecs[17] = mk(1, 10'h033, 0, 0, 2'b01, 10'h002, 10'h000, 1, 2, 2'b00, 0, 0, 7, 0, 0, 0);
        vecs[18] = mk(0, 10'h3FF, 1, 4, 2'b11, 10'h004, 10'h004, 0, 0, 2'b11, 4, 4, 8, 1, 0, 0);
        vecs[19] = mk(0, 10'h3FF, 0, 0, 2'b11, 10'h004, 10'h004, 1, 4, 2'b00, 0, 0, 7, 0, 0, 0);
        vecs[20] = mk(0, 10'h3FF, 1, 4, 2'b00, 10'h000, 10'h000, 1, 4, 2'b00, 0, 0, 7, 0, 0, 0);
        vecs[21] = mk(0, 10'h3FF, 0, 0, 2'b00, 10'h000, 10'h000, 1, 4, 2'b00, 0, 0, 7, 0, 0, 1);
        vecs[22] = mk(0, 10'h3FF, 1, 1, 2'b00, 10'h000, 10'h000, 1, 4, 2'b00, 0, 0, 7, 0, 0, 1);
        vecs[23] = mk(0, 10'h3FF, 0, 0, 2'b00, 10'h000, 10'h000, 1, 1, 2'b00, 0, 0, 6, 0, 0, 1);

        #1;
        chk("reset_state", {24'h0, occupancy, full, empty, err_release, alloc_ready},
            {24'h0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            alloc_valid   = vecs[i].av;
            alloc_set     = vecs[i].aset;
            release_valid = vecs[i].rv;
            release_idx   = vecs[i].ridx;
            lookup_valid  = vecs[i].lv;
            lookup_set    = {vecs[i].ls1, vecs[i].ls0};
            #1;
            aidx_act = vecs[i].e_ardy ? alloc_idx : 3'd0;
            aidx_exp = vecs[i].e_ardy ? vecs[i].e_aidx : 3'd0;
            act = {8'h0, alloc_ready, aidx_act, lookup_hit, lookup_idx[2:0], lookup_idx[5:3],
                   occupancy, full, empty, err_release};
            exp = {8'h0, vecs[i].e_ardy, aidx_exp, vecs[i].e_hit, vecs[i].e_idx0, vecs[i].e_idx1,
                   vecs[i].e_occ, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_err};
            chk($sformatf("vec%0d", i), act, exp);
        end

        // Asynchronous reset while an alloc burst is in progress.
        @(negedge clk);
        idle_inputs();
        alloc_valid = 1'b1;
        alloc_set   = 10'h100;
        @(posedge clk);
        #2;
        rst = 1'b1;
        lookup_valid = 2'b01;
        lookup_set   = {10'h000, 10'h006};
        #1;
        chk("async_rst_occ", {28'h0, occupancy}, 32'd0);
        chk("async_rst_flags", {29'h0, full, empty, err_release}, {29'h0, 1'b0, 1'b1, 1'b0});
        chk("async_rst_hit", {30'h0, lookup_hit}, 32'd0);
        chk("async_rst_alloc", {28'h0, alloc_ready, alloc_idx}, {28'h0, 1'b1, 3'd0});
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        // Duplicate allocation permitted on the ALLOW_DUP instance.
        @(negedge clk);
        d_alloc_valid = 1'b1;
        d_alloc_set   = 10'h005;
        #1;
        chk("dup_first", {28'h0, d_alloc_ready, d_alloc_idx}, {28'h0, 1'b1, 3'd0});
        @(negedge clk);
        #1;
        chk("dup_second", {28'h0, d_alloc_ready, d_alloc_idx}, {28'h0, 1'b1, 3'd1});
        @(negedge clk);
        d_alloc_valid  = 1'b0;
        d_lookup_valid = 2'b01;
        d_lookup_set   = 10'h005;
        #1;
        chk("dup_lookup", {24'h0, d_lookup_hit, d_lookup_idx[2:0], 3'd0},
            {24'h0, 2'b01, 3'd0, 3'd0});
        chk("dup_occ", {27'h0, d_occupancy, d_empty}, {27'h0, 4'd2, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
